// File: rtl/tmds_pkg.sv
// Shared TMDS symbol definitions: control tokens, token lookup and 10b->8b data decode.
// Kept free of decoder-specific state so the encoder side can import it as well.
package tmds_pkg;

  localparam int SYMBOL_W = 10;

  localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYMBOL_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } align_state_t;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctrl;
  } token_t;

  function automatic token_t classify_token(input logic [SYMBOL_W-1:0] w);
    token_t t;
    t.is_token = 1'b1;
    t.ctrl     = 2'b00;
    case (w)
      CTRL_TOKEN_00: t.ctrl = 2'b00;
      CTRL_TOKEN_01: t.ctrl = 2'b01;
      CTRL_TOKEN_10: t.ctrl = 2'b10;
      CTRL_TOKEN_11: t.ctrl = 2'b11;
      default:       t.is_token = 1'b0;
    endcase
    return t;
  endfunction

  // Bit 9 undoes the DC-balance inversion, bit 8 selects XOR vs XNOR chaining.
  function automatic logic [7:0] decode_data(input logic [SYMBOL_W-1:0] w);
    logic [7:0] d;
    logic [7:0] q;
    d    = w[9] ? ~w[7:0] : w[7:0];
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_channel_decoder_if.sv
// Per-lane bus between the deserializer/pixel sink (master) and the channel decoder (slave).
interface tmds_channel_decoder_if;
  import tmds_pkg::*;

  logic [SYMBOL_W-1:0] tmds_word;
  logic [7:0]          pixel_data;
  logic                den;
  logic [1:0]          ctrl;
  logic                aligned;
  logic [3:0]          bit_offset;
  logic                lock_lost;

  modport master (
    output tmds_word,
    input  pixel_data, den, ctrl, aligned, bit_offset, lock_lost
  );

  modport slave (
    input  tmds_word,
    output pixel_data, den, ctrl, aligned, bit_offset, lock_lost
  );

endinterface

// File: rtl/tmds_word_aligner.sv
// S1/S2 of the decoder: holds the previous word and barrel-selects a 10-bit symbol
// out of the 20-bit {current, previous} window at the requested bit offset.
module tmds_word_aligner
  import tmds_pkg::*;
(
  input  logic                pixel_clock,
  input  logic                resetn,
  input  logic [SYMBOL_W-1:0] tmds_word,
  input  logic [3:0]          bit_offset,
  output logic [SYMBOL_W-1:0] aligned_word
);

  logic [SYMBOL_W-1:0]   prev_word;
  logic [2*SYMBOL_W-1:0] window;
  logic [4:0]            sel;

  // Bit 0 is earliest on the wire, so older bits sit in the low half.
  assign window = {tmds_word, prev_word};
  assign sel    = {1'b0, bit_offset};

  always_ff @(posedge pixel_clock or negedge resetn) begin
    if (!resetn) begin
      prev_word    <= '0;
      aligned_word <= '0;
    end else begin
      prev_word    <= tmds_word;
      aligned_word <= window[sel +: SYMBOL_W];
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS lane receiver: word alignment search/lock FSM driven by control-token runs,
// plus the registered token/data decode stage.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 12,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 4096,
  parameter int CNT_W          = 13
) (
  input  logic                  pixel_clock,
  input  logic                  resetn,
  tmds_channel_decoder_if.slave bus
);

  localparam int                RUN_W        = $clog2(CTRL_RUN + 1);
  localparam logic [RUN_W-1:0]  RUN_TARGET   = RUN_W'(CTRL_RUN);
  localparam logic [CNT_W-1:0]  SEARCH_LIMIT = CNT_W'(SEARCH_TIMEOUT);
  localparam logic [CNT_W-1:0]  LOSS_LIMIT   = CNT_W'(LOSS_TIMEOUT);

  align_state_t        state, state_next;
  logic [RUN_W-1:0]    run_cnt, run_next, run_inc;
  logic [CNT_W-1:0]    timer, timer_next, timer_inc;
  logic [1:0]          settle_cnt, settle_next;
  logic [3:0]          offset, offset_next, offset_inc;
  logic                lost_next;
  logic [SYMBOL_W-1:0] aligned_word;
  token_t              tok;
  logic [7:0]          pixel_q;
  logic                den_q;
  logic [1:0]          ctrl_q;
  logic                lost_q;

  tmds_word_aligner u_aligner (
    .pixel_clock  (pixel_clock),
    .resetn       (resetn),
    .tmds_word    (bus.tmds_word),
    .bit_offset   (offset),
    .aligned_word (aligned_word)
  );

  assign tok        = classify_token(aligned_word);
  assign run_inc    = (run_cnt == '1) ? run_cnt : run_cnt + RUN_W'(1);
  assign timer_inc  = (timer == '1) ? timer : timer + CNT_W'(1);
  assign offset_inc = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  always_ff @(posedge pixel_clock or negedge resetn) begin
    if (!resetn) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      timer      <= '0;
      settle_cnt <= '0;
      offset     <= '0;
      lost_q     <= 1'b0;
      pixel_q    <= '0;
      den_q      <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      state      <= state_next;
      run_cnt    <= run_next;
      timer      <= timer_next;
      settle_cnt <= settle_next;
      offset     <= offset_next;
      lost_q     <= lost_next;
      den_q      <= ~tok.is_token;
      ctrl_q     <= tok.is_token ? tok.ctrl : ctrl_q;
      pixel_q    <= tok.is_token ? pixel_q : decode_data(aligned_word);
    end
  end

  // One timer serves as search timeout and loss timeout; it is cleared on every state change.
  // After any offset change, settle_cnt masks the words still selected at the old offset.
  always_comb begin
    state_next  = state;
    run_next    = run_cnt;
    timer_next  = timer;
    settle_next = settle_cnt;
    offset_next = offset;
    lost_next   = 1'b0;
    case (state)
      SEARCH: begin
        if (settle_cnt != 2'd0) begin
          settle_next = settle_cnt - 2'd1;
          run_next    = '0;
        end else begin
          run_next = tok.is_token ? run_inc : '0;
        end
        if (settle_cnt == 2'd0 && tok.is_token && run_inc == RUN_TARGET) begin
          state_next = LOCKED;
          run_next   = '0;
          timer_next = '0;
        end else if (timer_inc == SEARCH_LIMIT) begin
          timer_next = '0;
          if (!tok.is_token) begin
            run_next    = '0;
            offset_next = offset_inc;
            settle_next = 2'd2;
          end
        end else begin
          timer_next = timer_inc;
        end
      end
      LOCKED: begin
        if (tok.is_token) begin
          timer_next = '0;
        end else if (timer_inc == LOSS_LIMIT) begin
          state_next  = SEARCH;
          lost_next   = 1'b1;
          timer_next  = '0;
          run_next    = '0;
          offset_next = offset_inc;
          settle_next = 2'd2;
        end else begin
          timer_next = timer_inc;
        end
      end
    endcase
  end

  assign bus.pixel_data = pixel_q;
  assign bus.den        = den_q;
  assign bus.ctrl       = ctrl_q;
  assign bus.aligned    = (state == LOCKED);
  assign bus.bit_offset = offset;
  assign bus.lock_lost  = lost_q;

endmodule
